// File: rtl/sequence_player.sv
// sequence_player: eight-channel playback of the sequence memory onto DAC outputs.
// Each channel walks addresses 0..E at its own step period; every step registers
// the fetched word onto the channel's DAC output with a one-cycle valid strobe.
module sequence_player #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned GAP_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [GAP_W-1:0]  reg_end_seq_addr,
    input  logic [GAP_W-1:0]  reg_time_gap_1,
    input  logic [GAP_W-1:0]  reg_time_gap_2,
    input  logic [GAP_W-1:0]  reg_time_gap_3,
    input  logic [GAP_W-1:0]  reg_time_gap_4,
    input  logic [GAP_W-1:0]  reg_time_gap_5,
    input  logic [GAP_W-1:0]  reg_time_gap_6,
    input  logic [GAP_W-1:0]  reg_time_gap_7,
    input  logic [GAP_W-1:0]  reg_time_gap_8,
    input  logic [DATA_W-1:0] memout_1,
    input  logic [DATA_W-1:0] memout_2,
    input  logic [DATA_W-1:0] memout_3,
    input  logic [DATA_W-1:0] memout_4,
    input  logic [DATA_W-1:0] memout_5,
    input  logic [DATA_W-1:0] memout_6,
    input  logic [DATA_W-1:0] memout_7,
    input  logic [DATA_W-1:0] memout_8,
    output logic [ADDR_W-1:0] seq_addr_1,
    output logic [ADDR_W-1:0] seq_addr_2,
    output logic [ADDR_W-1:0] seq_addr_3,
    output logic [ADDR_W-1:0] seq_addr_4,
    output logic [ADDR_W-1:0] seq_addr_5,
    output logic [ADDR_W-1:0] seq_addr_6,
    output logic [ADDR_W-1:0] seq_addr_7,
    output logic [ADDR_W-1:0] seq_addr_8,
    output logic [DATA_W-1:0] dac_out_1,
    output logic [DATA_W-1:0] dac_out_2,
    output logic [DATA_W-1:0] dac_out_3,
    output logic [DATA_W-1:0] dac_out_4,
    output logic [DATA_W-1:0] dac_out_5,
    output logic [DATA_W-1:0] dac_out_6,
    output logic [DATA_W-1:0] dac_out_7,
    output logic [DATA_W-1:0] dac_out_8,
    output logic              dac_valid_1,
    output logic              dac_valid_2,
    output logic              dac_valid_3,
    output logic              dac_valid_4,
    output logic              dac_valid_5,
    output logic              dac_valid_6,
    output logic              dac_valid_7,
    output logic              dac_valid_8,
    output logic              running,
    output logic              done
);

    localparam int unsigned NCH      = 8;
    localparam int unsigned MAX_ADDR = (1 << ADDR_W) - 1;
    localparam int unsigned MIN_GAP  = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [GAP_W-1:0]  gap_in  [NCH];
    logic [DATA_W-1:0] mem_in  [NCH];
    logic [ADDR_W-1:0] addr_q  [NCH];
    logic [DATA_W-1:0] dac_q   [NCH];
    logic [GAP_W-1:0]  gap_q   [NCH];
    logic [GAP_W-1:0]  cnt_q   [NCH];
    logic [NCH-1:0]    valid_q;
    logic [NCH-1:0]    fin_q;
    logic [ADDR_W-1:0] end_q;
    logic              loop_q;
    logic              running_q;
    logic              done_q;

    logic [NCH-1:0]    emit_c;
    logic [NCH-1:0]    fin_next_c;
    logic [ADDR_W-1:0] end_clamp_c;

    assign gap_in[0] = reg_time_gap_1;
    assign gap_in[1] = reg_time_gap_2;
    assign gap_in[2] = reg_time_gap_3;
    assign gap_in[3] = reg_time_gap_4;
    assign gap_in[4] = reg_time_gap_5;
    assign gap_in[5] = reg_time_gap_6;
    assign gap_in[6] = reg_time_gap_7;
    assign gap_in[7] = reg_time_gap_8;

    assign mem_in[0] = memout_1;
    assign mem_in[1] = memout_2;
    assign mem_in[2] = memout_3;
    assign mem_in[3] = memout_4;
    assign mem_in[4] = memout_5;
    assign mem_in[5] = memout_6;
    assign mem_in[6] = memout_7;
    assign mem_in[7] = memout_8;

    assign seq_addr_1 = addr_q[0];
    assign seq_addr_2 = addr_q[1];
    assign seq_addr_3 = addr_q[2];
    assign seq_addr_4 = addr_q[3];
    assign seq_addr_5 = addr_q[4];
    assign seq_addr_6 = addr_q[5];
    assign seq_addr_7 = addr_q[6];
    assign seq_addr_8 = addr_q[7];

    assign dac_out_1 = dac_q[0];
    assign dac_out_2 = dac_q[1];
    assign dac_out_3 = dac_q[2];
    assign dac_out_4 = dac_q[3];
    assign dac_out_5 = dac_q[4];
    assign dac_out_6 = dac_q[5];
    assign dac_out_7 = dac_q[6];
    assign dac_out_8 = dac_q[7];

    assign dac_valid_1 = valid_q[0];
    assign dac_valid_2 = valid_q[1];
    assign dac_valid_3 = valid_q[2];
    assign dac_valid_4 = valid_q[3];
    assign dac_valid_5 = valid_q[4];
    assign dac_valid_6 = valid_q[5];
    assign dac_valid_7 = valid_q[6];
    assign dac_valid_8 = valid_q[7];

    assign running = running_q;
    assign done    = done_q;

    // End address clamped to the last memory entry.
    assign end_clamp_c = (reg_end_seq_addr > GAP_W'(MAX_ADDR)) ? ADDR_W'(MAX_ADDR)
                                                                : reg_end_seq_addr[ADDR_W-1:0];

    // Per-channel emission decision and finished flags as they will be after this edge.
    always_comb begin
        emit_c     = '0;
        fin_next_c = fin_q;
        for (int i = 0; i < NCH; i++) begin
            emit_c[i] = (state == S_RUN) && !fin_q[i] && (cnt_q[i] == '0);
            if (emit_c[i] && (addr_q[i] == end_q) && !loop_q) begin
                fin_next_c[i] = 1'b1;
            end
        end
    end

    // Playback FSM, per-channel step counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= '0;
            fin_q     <= '0;
            end_q     <= '0;
            loop_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                addr_q[i] <= '0;
                dac_q[i]  <= '0;
                gap_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            valid_q <= '0;
            done_q  <= 1'b0;
            if (stop) begin
                state     <= S_IDLE;
                running_q <= 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    addr_q[i] <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_RUN;
                            running_q <= 1'b1;
                            end_q     <= end_clamp_c;
                            loop_q    <= loop_en;
                            fin_q     <= '0;
                            for (int i = 0; i < NCH; i++) begin
                                gap_q[i] <= (gap_in[i] < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP)
                                                                          : gap_in[i];
                                cnt_q[i] <= GAP_W'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        for (int i = 0; i < NCH; i++) begin
                            if (emit_c[i]) begin
                                dac_q[i]   <= mem_in[i];
                                valid_q[i] <= 1'b1;
                                cnt_q[i]   <= gap_q[i] - GAP_W'(1);
                                if (addr_q[i] != end_q) begin
                                    addr_q[i] <= addr_q[i] + ADDR_W'(1);
                                end else if (loop_q) begin
                                    addr_q[i] <= '0;
                                end
                            end else if (!fin_q[i] && (cnt_q[i] != '0)) begin
                                cnt_q[i] <= cnt_q[i] - GAP_W'(1);
                            end
                        end
                        fin_q <= fin_next_c;
                        if (&fin_next_c) begin
                            state     <= S_IDLE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                            for (int i = 0; i < NCH; i++) begin
                                addr_q[i] <= '0;
                            end
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
